fetch_pc_unit: RTL

//  Instruction-fetch stage directly upstream of the branch address calculator.

---
 rtl/if_pkg.sv | 13 +
 rtl/if_skid_buf.sv | 41 ++++
 rtl/fetch_pc_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD,
    DROP
  } fetch_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, inst} buffer holding a returned instruction while decode is stalled.
module if_skid_buf
  import if_pkg::*;
#(
  parameter int unsigned WordSize = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic                i_clear,
  input  logic [WordSize-1:0] i_pc,
  input  logic [WordSize-1:0] i_inst,
  output logic                o_full,
  output logic [WordSize-1:0] o_pc,
  output logic [WordSize-1:0] o_inst
);

  logic                r_full;
  logic [WordSize-1:0] r_pc;
  logic [WordSize-1:0] r_inst;

  // Clear wins over load so a redirect always empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_pc   <= '0;
      r_inst <= WordSize'(NOP_INST);
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_pc   <= i_pc;
      r_inst <= i_inst;
    end
  end

  assign o_full = r_full;
  assign o_pc   = r_pc;
  assign o_inst = r_inst;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, issues one outstanding imem request and fills IF/ID.
module fetch_pc_unit
  import if_pkg::*;
#(
  parameter int unsigned           WordSize    = 32,
  parameter logic [WordSize-1:0]   ResetVector = '0,
  parameter int unsigned           PcStep      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                branch_taken,
  input  logic [WordSize-1:0] npc,
  input  logic                stall,
  input  logic                imem_ack,
  input  logic [WordSize-1:0] imem_data,
  output logic                imem_req,
  output logic [WordSize-1:0] imem_addr,
  output logic [WordSize-1:0] pc,
  output logic [WordSize-1:0] if_pc,
  output logic [WordSize-1:0] if_inst,
  output logic                if_valid
);

  fetch_state_t        r_state, w_state_d;
  logic [WordSize-1:0] r_pc, w_pc_d;
  logic [WordSize-1:0] r_addr, w_addr_d;
  logic                r_req, w_req_d;
  logic [WordSize-1:0] r_if_pc, w_if_pc_d;
  logic [WordSize-1:0] r_if_inst, w_if_inst_d;
  logic                r_if_valid, w_if_valid_d;

  logic                w_skid_load;
  logic                w_skid_clear;
  logic                w_skid_full;
  logic [WordSize-1:0] w_skid_pc;
  logic [WordSize-1:0] w_skid_inst;

  logic [WordSize-1:0] w_npc_al;
  logic [WordSize-1:0] w_pc_inc;

  assign w_npc_al = {npc[WordSize-1:2], 2'b00};
  assign w_pc_inc = r_pc + WordSize'(PcStep);

  if_skid_buf #(
    .WordSize(WordSize)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_skid_load),
    .i_clear(w_skid_clear),
    .i_pc   (r_addr),
    .i_inst (imem_data),
    .o_full (w_skid_full),
    .o_pc   (w_skid_pc),
    .o_inst (w_skid_inst)
  );

  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_addr_d     = r_addr;
    w_req_d      = r_req;
    w_if_pc_d    = r_if_pc;
    w_if_inst_d  = r_if_inst;
    w_if_valid_d = r_if_valid;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;

    unique case (r_state)
      BOOT: begin
        w_state_d = FETCH;
        w_req_d   = 1'b1;
        if (branch_taken) begin
          w_pc_d   = w_npc_al;
          w_addr_d = w_npc_al;
        end else begin
          w_addr_d = r_pc;
        end
      end

      FETCH: begin
        if (branch_taken) begin
          w_pc_d       = w_npc_al;
          w_if_valid_d = 1'b0;
          w_skid_clear = 1'b1;
          // A response in the redirect cycle is dropped; otherwise wait it out in DROP.
          if (imem_ack) begin
            w_addr_d = w_npc_al;
          end else begin
            w_state_d = DROP;
          end
        end else if (imem_ack) begin
          w_pc_d   = w_pc_inc;
          w_addr_d = w_pc_inc;
          if (r_if_valid && stall) begin
            w_skid_load = 1'b1;
            w_req_d     = 1'b0;
            w_state_d   = HOLD;
          end else begin
            w_if_pc_d    = r_addr;
            w_if_inst_d  = imem_data;
            w_if_valid_d = 1'b1;
          end
        end else if (!stall) begin
          w_if_valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          w_pc_d       = w_npc_al;
          w_addr_d     = w_npc_al;
          w_req_d      = 1'b1;
          w_if_valid_d = 1'b0;
          w_skid_clear = 1'b1;
          w_state_d    = FETCH;
        end else if (!stall) begin
          w_if_pc_d    = w_skid_pc;
          w_if_inst_d  = w_skid_inst;
          w_if_valid_d = w_skid_full;
          w_skid_clear = 1'b1;
          w_addr_d     = r_pc;
          w_req_d      = 1'b1;
          w_state_d    = FETCH;
        end
      end

      DROP: begin
        w_if_valid_d = 1'b0;
        if (branch_taken) begin
          w_pc_d       = w_npc_al;
          w_skid_clear = 1'b1;
        end
        if (imem_ack) begin
          w_addr_d  = branch_taken ? w_npc_al : r_pc;
          w_state_d = FETCH;
        end
      end

      default: begin
        w_state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= BOOT;
      r_pc       <= ResetVector;
      r_addr     <= ResetVector;
      r_req      <= 1'b0;
      r_if_pc    <= '0;
      r_if_inst  <= WordSize'(NOP_INST);
      r_if_valid <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_addr     <= w_addr_d;
      r_req      <= w_req_d;
      r_if_pc    <= w_if_pc_d;
      r_if_inst  <= w_if_inst_d;
      r_if_valid <= w_if_valid_d;
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign pc        = r_pc;
  assign if_pc     = r_if_pc;
  assign if_inst   = r_if_inst;
  assign if_valid  = r_if_valid;

endmodule
